// File: rtl/cpu_test_ctrl.sv
// cpu_test_ctrl: run controller and self-checker for the RV32IM pipeline.
// It sequences the CPU reset, counts run cycles and watches the dmem store port
// for the tohost signature store. It also catches a timeout or a stuck pc, and
// then latches the pass/fail result until the next start.
// Optional feature: define CPU_TEST_HIST_EN to add a ring buffer holding the
// most recent distinct pc values. It is read back through hist_idx/hist_pc.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, CPU held in reset, waiting for start
// S_RSTSEQ| CPU reset held for RST_CYCLES cycles, results cleared
// S_RUN   | CPU released, counting cycles, watching store/pc
// S_DONE  | result latched, CPU frozen in reset, waiting for start
module cpu_test_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                RST_CYCLES  = 2,
    parameter int                TIMEOUT     = 4096,
    parameter int                STALL_LIMIT = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0FF0,
    parameter int                HIST_DEPTH  = 8,
    localparam int               HIST_W      = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [31:0]       cycle_count,
    output logic [DATA_W-1:0] tohost_value,
    input  logic [HIST_W-1:0] hist_idx,
    output logic [ADDR_W-1:0] hist_pc
);

    typedef enum logic [1:0] {S_IDLE, S_RSTSEQ, S_RUN, S_DONE} state_t;

    localparam int               RST_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD   = RST_W'(RST_CYCLES - 1);
    localparam int               STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_TC = STALL_W'(STALL_LIMIT - 1);
    localparam logic [31:0]      TIMEOUT_TC = 32'(TIMEOUT - 1);

    state_t             state, state_next;
    logic [RST_W-1:0]   rst_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [ADDR_W-1:0]  pc_prev;
    logic               pc_valid;
    logic               pc_changed;
    logic               sig_hit, timeout_hit, stall_hit;
    logic               enter_rst;

    // Next-state decode and end-of-run event detection.
    always_comb begin
        state_next  = state;
        pc_changed  = !pc_valid || (pc != pc_prev);
        sig_hit     = (state == S_RUN) && (mem_write != 2'b00) && (mem_addr == TOHOST_ADDR);
        timeout_hit = (state == S_RUN) && (cycle_count == TIMEOUT_TC);
        stall_hit   = (state == S_RUN) && !pc_changed && (stall_cnt == STALL_TC);
        case (state)
            S_IDLE:   if (start) state_next = S_RSTSEQ;
            S_RSTSEQ: if (rst_cnt == '0) state_next = S_RUN;
            S_RUN:    if (sig_hit || timeout_hit || stall_hit) state_next = S_DONE;
            S_DONE:   if (start) state_next = S_RSTSEQ;
            default:  state_next = S_IDLE;
        endcase
        enter_rst = (state_next == S_RSTSEQ) && (state != S_RSTSEQ);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    assign cpu_reset = (state != S_RUN);
    assign done      = (state == S_DONE);

    // Reset-sequence timer, run counters, stall tracking and result latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt      <= '0;
            cycle_count  <= '0;
            stall_cnt    <= '0;
            pc_prev      <= '0;
            pc_valid     <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= 2'b00;
            tohost_value <= '0;
        end else if (enter_rst) begin
            rst_cnt      <= RST_LOAD;
            cycle_count  <= '0;
            stall_cnt    <= '0;
            pc_valid     <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= 2'b00;
            tohost_value <= '0;
        end else begin
            if (state == S_RSTSEQ && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
            if (state == S_RUN) begin
                if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
                pc_prev   <= pc;
                pc_valid  <= 1'b1;
                stall_cnt <= pc_changed ? '0 : stall_cnt + 1'b1;
                if (sig_hit) begin
                    tohost_value <= mem_wdata;
                    pass         <= (mem_wdata == DATA_W'(1));
                    fail_code    <= (mem_wdata == DATA_W'(1)) ? 2'b00 : 2'b01;
                end else if (timeout_hit) begin
                    fail_code <= 2'b10;
                end else if (stall_hit) begin
                    fail_code <= 2'b11;
                end
            end
        end
    end

`ifdef CPU_TEST_HIST_EN
    logic [ADDR_W-1:0] hist_mem [HIST_DEPTH];
    logic [HIST_W-1:0] hist_wptr;

    // pc history ring: records each new pc seen in RUN, cleared when a run starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_wptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (enter_rst) begin
            hist_wptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (state == S_RUN && pc_changed) begin
            hist_mem[hist_wptr] <= pc;
            hist_wptr           <= hist_wptr + 1'b1;
        end
    end

    // hist_wptr points at the next free slot, so the newest entry is one behind it.
    assign hist_pc = hist_mem[hist_wptr - HIST_W'(1) - hist_idx];
`else
    logic hist_idx_unused;
    assign hist_idx_unused = ^hist_idx;
    assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Directed testbench for cpu_test_ctrl (RST_CYCLES=2, TIMEOUT=100, STALL_LIMIT=64).
module tb_cpu_test_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic [1:0]  mem_write = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        cpu_reset, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] cycle_count, tohost_value;
    logic [2:0]  hist_idx = '0;
    logic [31:0] hist_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_test_ctrl #(
        .ADDR_W(32), .DATA_W(32), .RST_CYCLES(2), .TIMEOUT(100),
        .STALL_LIMIT(64), .TOHOST_ADDR(32'h0000_0FF0), .HIST_DEPTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pc(pc),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .pass(pass), .fail_code(fail_code),
        .cycle_count(cycle_count), .tohost_value(tohost_value),
        .hist_idx(hist_idx), .hist_pc(hist_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and walk through the reset sequence into RUN cycle 0.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rstseq1_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstseq_done_clr got=%b exp=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL rstseq_pass_clr got=%b exp=0", pass); end
        total++; if (fail_code !== 2'b00) begin bad++; $display("FAIL rstseq_fail_clr got=%b exp=00", fail_code); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL rstseq_count_clr got=%0d exp=0", cycle_count); end
        total++; if (tohost_value !== 32'd0) begin bad++; $display("FAIL rstseq_tohost_clr got=%0h exp=0", tohost_value); end
        step();
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rstseq2_cpu_reset got=%b exp=1", cpu_reset); end
        step();
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL run_cpu_reset got=%b exp=0", cpu_reset); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL run_count_start got=%0d exp=0", cycle_count); end
    endtask

    task automatic test_reset();
        #2;
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
        total++; if (fail_code !== 2'b00) begin bad++; $display("FAIL reset_fail_code got=%b exp=00", fail_code); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
        total++; if (tohost_value !== 32'd0) begin bad++; $display("FAIL reset_tohost got=%0h exp=0", tohost_value); end
        total++; if (hist_pc !== 32'd0) begin bad++; $display("FAIL reset_hist got=%0h exp=0", hist_pc); end
        step();
        reset_n = 1'b1;
        step();
        step();
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL idle_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b exp=0", done); end
    endtask

    task automatic test_pass();
        do_start();
        for (int k = 0; k <= 20; k++) begin
            pc = 32'(k * 4);
            if (k == 20) begin mem_write = 2'b01; mem_addr = 32'h0FF0; mem_wdata = 32'h1; end
            step();
            mem_write = 2'b00;
            if (k == 19) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_early_done got=%b exp=0", done); end
                total++; if (cycle_count !== 32'd20) begin bad++; $display("FAIL pass_count20 got=%0d exp=20", cycle_count); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL pass_done got=%b exp=1", done); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL pass_pass got=%b exp=1", pass); end
        total++; if (fail_code !== 2'b00) begin bad++; $display("FAIL pass_code got=%b exp=00", fail_code); end
        total++; if (cycle_count !== 32'd21) begin bad++; $display("FAIL pass_count got=%0d exp=21", cycle_count); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL pass_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (tohost_value !== 32'h1) begin bad++; $display("FAIL pass_tohost got=%0h exp=1", tohost_value); end
        step();
        step();
        total++; if (cycle_count !== 32'd21) begin bad++; $display("FAIL pass_frozen got=%0d exp=21", cycle_count); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL pass_done_held got=%b exp=1", done); end
    endtask

    task automatic test_fail_code();
        do_start();
        for (int k = 0; k <= 10; k++) begin
            pc = 32'(k * 4);
            if (k == 5)  begin mem_write = 2'b10; mem_addr = 32'h0FF4; mem_wdata = 32'h1; end
            if (k == 10) begin mem_write = 2'b01; mem_addr = 32'h0FF0; mem_wdata = 32'h7; end
            step();
            mem_write = 2'b00;
            if (k == 5) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL other_addr_done got=%b exp=0", done); end
                total++; if (tohost_value !== 32'h0) begin bad++; $display("FAIL other_addr_tohost got=%0h exp=0", tohost_value); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fail_done got=%b exp=1", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL fail_pass got=%b exp=0", pass); end
        total++; if (fail_code !== 2'b01) begin bad++; $display("FAIL fail_code got=%b exp=01", fail_code); end
        total++; if (tohost_value !== 32'h7) begin bad++; $display("FAIL fail_tohost got=%0h exp=7", tohost_value); end
        total++; if (cycle_count !== 32'd11) begin bad++; $display("FAIL fail_count got=%0d exp=11", cycle_count); end
        mem_write = 2'b11; mem_addr = 32'h0FF0; mem_wdata = 32'h1;
        step();
        step();
        mem_write = 2'b00;
        total++; if (tohost_value !== 32'h7) begin bad++; $display("FAIL done_store_tohost got=%0h exp=7", tohost_value); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL done_store_pass got=%b exp=0", pass); end
    endtask

    task automatic test_timeout();
        do_start();
        for (int k = 0; k <= 99; k++) begin
            pc = 32'(k * 4);
            start = (k == 50);
            step();
            start = 1'b0;
            if (k == 98) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", done); end
            end
            if (k == 51) begin
                total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL run_start_ignored got=%b exp=0", cpu_reset); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL timeout_done got=%b exp=1", done); end
        total++; if (fail_code !== 2'b10) begin bad++; $display("FAIL timeout_code got=%b exp=10", fail_code); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL timeout_pass got=%b exp=0", pass); end
        total++; if (cycle_count !== 32'd100) begin bad++; $display("FAIL timeout_count got=%0d exp=100", cycle_count); end
    endtask

    task automatic test_stall();
        do_start();
        for (int k = 0; k <= 74; k++) begin
            pc = (k < 10) ? 32'(k * 4) : 32'd40;
            step();
            if (k == 73) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", done); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", done); end
        total++; if (fail_code !== 2'b11) begin bad++; $display("FAIL stall_code got=%b exp=11", fail_code); end
        total++; if (cycle_count !== 32'd75) begin bad++; $display("FAIL stall_count got=%0d exp=75", cycle_count); end
    endtask

    task automatic test_sig_vs_timeout();
        do_start();
        for (int k = 0; k <= 99; k++) begin
            pc = 32'(k * 4);
            if (k == 99) begin mem_write = 2'b01; mem_addr = 32'h0FF0; mem_wdata = 32'h7; end
            step();
            mem_write = 2'b00;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL prio_done got=%b exp=1", done); end
        total++; if (fail_code !== 2'b01) begin bad++; $display("FAIL prio_code got=%b exp=01", fail_code); end
        total++; if (tohost_value !== 32'h7) begin bad++; $display("FAIL prio_tohost got=%0h exp=7", tohost_value); end
    endtask

    task automatic test_history();
        logic [31:0] exp0, exp7, exp1;
`ifdef CPU_TEST_HIST_EN
        exp0 = 32'd40; exp7 = 32'd12; exp1 = 32'd36;
`else
        exp0 = 32'd0;  exp7 = 32'd0;  exp1 = 32'd0;
`endif
        do_start();
        for (int k = 0; k <= 13; k++) begin
            pc = (k <= 10) ? 32'(k * 4) : 32'd40;
            if (k == 13) begin mem_write = 2'b01; mem_addr = 32'h0FF0; mem_wdata = 32'h1; end
            step();
            mem_write = 2'b00;
        end
        pc = 32'h100;
        step();
        hist_idx = 3'd0; #1;
        total++; if (hist_pc !== exp0) begin bad++; $display("FAIL hist_idx0 got=%0h exp=%0h", hist_pc, exp0); end
        hist_idx = 3'd7; #1;
        total++; if (hist_pc !== exp7) begin bad++; $display("FAIL hist_idx7 got=%0h exp=%0h", hist_pc, exp7); end
        hist_idx = 3'd1; #1;
        total++; if (hist_pc !== exp1) begin bad++; $display("FAIL hist_idx1 got=%0h exp=%0h", hist_pc, exp1); end
        hist_idx = 3'd0;
    endtask

    task automatic test_reset_midrun();
        do_start();
        for (int k = 0; k < 30; k++) begin
            pc = 32'(k * 4);
            step();
        end
        total++; if (cycle_count !== 32'd30) begin bad++; $display("FAIL midrun_count got=%0d exp=30", cycle_count); end
        reset_n = 1'b0;
        step();
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL midrun_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL midrun_count_clr got=%0d exp=0", cycle_count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrun_done got=%b exp=0", done); end
        total++; if (hist_pc !== 32'd0) begin bad++; $display("FAIL midrun_hist got=%0h exp=0", hist_pc); end
        reset_n = 1'b1;
        step();
        step();
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL midrun_idle got=%b exp=1", cpu_reset); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL midrun_idle_count got=%0d exp=0", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_code();
        test_timeout();
        test_stall();
        test_sig_vs_timeout();
        test_history();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
